// File: rtl/fifo_defs_pkg.sv
// Shared FIFO sizing definitions for transaction-layer blocks.
// Any block that stores or compares an occupancy count sizes it with
// cnt_size() so that all count ports along a channel agree in width.
package fifo_defs;

    localparam int DEF_MEM_DEPTH = 8;
    localparam int DEF_WORD_SIZE = 10;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_size(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/memoria_dp.sv
// Dual-port storage array: one write port, one registered read port.
// The array is never reset. Only the read data register is reset, so the
// output is defined right after reset.
module memoria_dp #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Write port: store the incoming word. The array itself has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: register the addressed word. When both ports hit the same
    // address on the same edge, the old word is returned (read before write).
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with occupancy count, run-time almost-full and
// almost-empty thresholds, and sticky overflow and underflow flags.
// It holds the pointers, count and error state. The words live in memoria_dp.
module fifo_umbrales
    import fifo_defs::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int PTR_SIZE  = $clog2(MEM_DEPTH),
    parameter int CNT_SIZE  = cnt_size(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 wr_en,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 rd_en,
    input  logic [CNT_SIZE-1:0]  umbral_alto,
    input  logic [CNT_SIZE-1:0]  umbral_bajo,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_SIZE-1:0]  fifo_count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 err_overflow,
    output logic                 err_underflow
);

    localparam logic [PTR_SIZE-1:0] LAST_PTR = PTR_SIZE'(MEM_DEPTH - 1);
    localparam logic [CNT_SIZE-1:0] FULL_CNT = CNT_SIZE'(MEM_DEPTH);

    logic [PTR_SIZE-1:0] wr_ptr_r;
    logic [PTR_SIZE-1:0] rd_ptr_r;
    logic [CNT_SIZE-1:0] count_r;
    logic                valid_r;
    logic                err_ovf_r;
    logic                err_unf_r;

    logic                full_s;
    logic                empty_s;
    logic                rd_ok_s;
    logic                wr_ok_s;
    logic                ovf_evt_s;
    logic                unf_evt_s;
    logic [PTR_SIZE-1:0] wr_ptr_nxt_s;
    logic [PTR_SIZE-1:0] rd_ptr_nxt_s;
    logic [CNT_SIZE-1:0] count_nxt_s;

    // Status flags decode the registered count directly, so a threshold
    // change is visible in the same cycle.
    always_comb begin
        full_s       = (count_r == FULL_CNT);
        empty_s      = (count_r == {CNT_SIZE{1'b0}});
        almost_full  = (count_r >= umbral_alto);
        almost_empty = (count_r <= umbral_bajo);
    end

    // Accept logic. A read frees a slot in the same cycle, so a full FIFO can
    // take a write together with a read. There is no fall-through when empty.
    always_comb begin
        rd_ok_s   = rd_en && !empty_s;
        wr_ok_s   = wr_en && (!full_s || rd_ok_s);
        ovf_evt_s = wr_en && !wr_ok_s;
        unf_evt_s = rd_en && empty_s;
    end

    // Next pointers wrap explicitly at MEM_DEPTH-1, so the depth need not be
    // a power of two.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_ok_s) begin
            if (wr_ptr_r == LAST_PTR) begin
                wr_ptr_nxt_s = {PTR_SIZE{1'b0}};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_SIZE'(1);
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_ok_s) begin
            if (rd_ptr_r == LAST_PTR) begin
                rd_ptr_nxt_s = {PTR_SIZE{1'b0}};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_SIZE'(1);
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Occupancy update. A simultaneous read and write leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_SIZE'(1);
            2'b01:   count_nxt_s = count_r - CNT_SIZE'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, count, read-valid pulse and sticky error flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            valid_r   <= 1'b0;
            err_ovf_r <= 1'b0;
            err_unf_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            valid_r   <= rd_ok_s;
            err_ovf_r <= err_ovf_r | ovf_evt_s;
            err_unf_r <= err_unf_r | unf_evt_s;
        end
    end

    memoria_dp #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (WORD_SIZE),
        .PTR_W (PTR_SIZE)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (data_in),
        .rd_en   (rd_ok_s),
        .rd_addr (rd_ptr_r),
        .rd_data (data_out)
    );

    assign valid_out     = valid_r;
    assign fifo_count    = count_r;
    assign full          = full_s;
    assign empty         = empty_s;
    assign err_overflow  = err_ovf_r;
    assign err_underflow = err_unf_r;

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales. It uses directed steps followed by
// random traffic. Every step is checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo_umbrales;

    localparam int DEPTH = 8;
    localparam int W     = 10;
    localparam int CW    = 4;

    logic          clk;
    logic          reset_L;
    logic          wr_en;
    logic [W-1:0]  data_in;
    logic          rd_en;
    logic [CW-1:0] umbral_alto;
    logic [CW-1:0] umbral_bajo;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic [CW-1:0] fifo_count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          err_overflow;
    logic          err_underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;

    fifo_umbrales dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .wr_en         (wr_en),
        .data_in       (data_in),
        .rd_en         (rd_en),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .fifo_count    (fifo_count),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n;
        n = m_q.size();
        chk({tag, ".full"},  32'(full),         32'(n == DEPTH));
        chk({tag, ".empty"}, 32'(empty),        32'(n == 0));
        chk({tag, ".af"},    32'(almost_full),  32'(n >= int'(umbral_alto)));
        chk({tag, ".ae"},    32'(almost_empty), 32'(n <= int'(umbral_bajo)));
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(fifo_count), 32'(m_q.size()));
        chk({tag, ".valid"}, 32'(valid_out),  32'(m_valid));
        chk({tag, ".data"},  32'(data_out),   32'(m_data));
        chk({tag, ".ovf"},   32'(err_overflow),  32'(m_ovf));
        chk({tag, ".unf"},   32'(err_underflow), 32'(m_unf));
        chk_flags(tag);
    endtask

    // One clock cycle with the given request, model update, full check.
    task automatic step(input string tag, input logic w, input logic [W-1:0] d, input logic r);
        bit rok;
        bit wok;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        rok = r && (m_q.size() != 0);
        wok = w && ((m_q.size() < DEPTH) || rok);
        if (w && !wok)               m_ovf = 1'b1;
        if (r && (m_q.size() == 0))  m_unf = 1'b1;
        @(posedge clk);
        #1;
        if (rok) begin
            m_data  = m_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (wok) m_q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_all(tag);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    initial begin
        reset_L     = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        data_in     = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset_L = 1'b1;

        // Fill with 0x001..0x008
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, W'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_af",   32'(almost_full), 32'd1);

        // Drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1);
            chk("drain_seq", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_noerr", 32'({err_overflow, err_underflow}), 32'd0);

        // Overflow: write while full is dropped, oldest word preserved
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, W'(16 + i), 1'b0);
        step("ovf", 1'b1, 10'h3FF, 1'b0);
        step("ovf_hold", 1'b0, '0, 1'b0);
        step("ovf_read", 1'b0, '0, 1'b1);
        chk("ovf_oldest", 32'(data_out), 32'h10);
        step("top_up", 1'b1, 10'h0AA, 1'b0);

        // Simultaneous read and write while full, exercising pointer wrap
        for (int i = 0; i < 20; i++) step("rw_full", 1'b1, W'($urandom_range(0, 1023)), 1'b1);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1);

        // Underflow: read alone, then read together with a write
        step("unf_alone", 1'b0, '0, 1'b1);
        step("unf_rw", 1'b1, 10'h155, 1'b1);
        step("unf_next", 1'b0, '0, 1'b1);
        chk("unf_word", 32'(data_out), 32'h155);

        // Random traffic with thresholds that change between cycles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                umbral_alto = CW'($urandom_range(0, DEPTH));
                umbral_bajo = CW'($urandom_range(0, DEPTH));
                #1;
                chk_flags("thr_now");
            end
            step("rand", 1'($urandom_range(0, 1)), W'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-operation with five words stored
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        while (m_q.size() > 0) step("pre_rst", 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step("pre_rst_fill", 1'b1, W'(32 + i), 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        reset_L = 1'b1;
        step("post_wr", 1'b1, 10'h2C3, 1'b0);
        step("post_rd", 1'b0, '0, 1'b1);
        chk("post_word", 32'(data_out), 32'h2C3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Parametrised synchronous FIFO with pointer management, occupancy count, run-time almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It combines a dual-port storage array with write/read control, so transaction-layer blocks get a complete buffer instead of a bare memory driven by external pointers. It sits between the transaction-layer producers and consumers, one instance per channel.

## Interface

- MEM_DEPTH, 8, number of words; any value ≥ 2, not required to be a power of two
- WORD_SIZE, 10, data width in bits
- PTR_SIZE, $clog2(MEM_DEPTH), pointer width
- CNT_SIZE, PTR_SIZE+1, width of count and threshold ports; must represent 0..MEM_DEPTH
- clk  in  1  single clock; all state changes on rising edge
- reset_L  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- data_in  in  WORD_SIZE  write data
- rd_en  in  1  read request
- umbral_alto  in  CNT_SIZE  almost-full threshold, sampled every cycle
- umbral_bajo  in  CNT_SIZE  almost-empty threshold, sampled every cycle
- data_out  out  WORD_SIZE  read data, registered
- valid_out  out  1  one-cycle pulse: data_out carries a newly read word
- fifo_count  out  CNT_SIZE  words stored, registered
- full, empty  out  1  fifo_count == MEM_DEPTH / fifo_count == 0
- almost_full  out  1  fifo_count ≥ umbral_alto
- almost_empty  out  1  fifo_count ≤ umbral_bajo
- err_overflow, err_underflow  out  1  sticky error flags

## Operation

- Read accepted (rd_ok) when rd_en && !empty.
- Write accepted (wr_ok) when wr_en && (!full || rd_ok).
- wr_ok: mem[wr_ptr] ← data_in; wr_ptr advances; MEM_DEPTH-1 wraps to 0.
- rd_ok: data_out ← mem[rd_ptr]; valid_out ← 1 for that cycle; rd_ptr advances with the same wrap. Without rd_ok: valid_out ← 0 and data_out holds its last value.
- fifo_count: +1 on wr_ok only, −1 on rd_ok only, unchanged on both or neither.
- Simultaneous read and write when full: both accepted, count stays MEM_DEPTH, no error.
- Simultaneous read and write when empty: write accepted, read rejected (no fall-through), err_underflow set.
- wr_en while full without rd_ok: word dropped, pointers and count unchanged, err_overflow ← 1.
- rd_en while empty: err_underflow ← 1, data_out holds, valid_out 0.
- Error flags clear only on reset.
- full, empty, almost_full and almost_empty are combinational decodes of the registered fifo_count and the threshold inputs. A threshold change takes effect in the same cycle.
- Asynchronous reset values: wr_ptr, rd_ptr, fifo_count, data_out, valid_out, err_overflow and err_underflow are 0; empty is 1; full is 0. Storage contents are not reset; the read pointer guarantees no word is returned before it has been written.
- Reset asserted mid-operation discards all buffered words immediately. Operation resumes on the first rising edge after reset_L deasserts.

## Timing

- Write to earliest readout: a word written at edge N is readable at edge N+1 (empty drops after N). data_out and valid_out are valid after edge N+1. Minimum latency is 2 cycles from wr_en to data_out.
- Read latency: 1 cycle from rd_en sampled to data_out/valid_out.
- Flags follow fifo_count with zero added cycles. Full throughput is one write and one read per cycle.

## Structure

- Shared package/include `fifo_defs`: default MEM_DEPTH and WORD_SIZE, and a CNT_SIZE helper macro/function so other transaction-layer blocks size counts identically.
- One sub-module, `memoria_dp`: storage array with a registered read port and no reset on the array. fifo_umbrales holds the pointers, count, flags and error logic.

## Test plan

- Reset, then write 0x001..0x008 in consecutive cycles (depth 8). full=1 after the 8th edge, count=8, almost_full asserts when count reaches umbral_alto=6.
- Read 8 consecutive cycles. data_out sequence is 0x001..0x008 with valid_out high for 8 cycles. empty=1 and almost_empty=1 (umbral_bajo=2) at the end. No error flags.
- When full, assert wr_en with 0x3FF. Word is dropped, err_overflow=1 and stays set. A later read returns the original oldest word.
- Simultaneous wr_en+rd_en when full: count stays 8, read returns the oldest word, the new word is stored. Run 20 cycles to exercise pointer wrap; output order matches a reference queue.
- rd_en while empty, alone and together with wr_en=0x155: err_underflow=1, valid_out=0, data_out unchanged. In the combined case count becomes 1 and the next read returns 0x155.
- Assert reset_L=0 asynchronously between edges with count=5. Count, pointers, data_out and error flags drop to 0 immediately and empty=1. After release, one write/read pair returns the new word.
